// File: rtl/ldq_dispatch_alloc.sv
// ldq_dispatch_alloc: load-queue ID allocator for the dispatch stage.
// Assigns LDQ entries to the load slots of each dispatch bundle and
// owns the head/tail/occupancy registers of the load queue.
// Optional macro LDQ_RETIRE_BYPASS_EN: loads retired this cycle count as
// free space for the bundle being dispatched in the same cycle.
module ldq_dispatch_alloc #(
  parameter int DISPATCH_WIDTH = 4,
  parameter int LDQ_DEPTH      = 32,
  parameter int LDQ_LOG        = 5,
  parameter int RETIRE_WIDTH   = 4,
  localparam int RCW = $clog2(RETIRE_WIDTH + 1),
  localparam int NCW = $clog2(DISPATCH_WIDTH + 1)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              dispatchValid_i,
  input  logic                              backendStall_i,
  input  logic [DISPATCH_WIDTH-1:0]         instLoad_i,
  input  logic [RCW-1:0]                    retireCnt_i,
  input  logic                              recoverValid_i,
  input  logic [LDQ_LOG:0]                  recoverCnt_i,
  input  logic                              flush_i,
  output logic [DISPATCH_WIDTH*LDQ_LOG-1:0] ldqId_o,
  output logic [DISPATCH_WIDTH*LDQ_LOG-1:0] nextLd_o,
  output logic [NCW-1:0]                    cntLdNew_o,
  output logic                              ldqStall_o,
  output logic                              allocFire_o,
  output logic [LDQ_LOG-1:0]                ldqHead_o,
  output logic [LDQ_LOG-1:0]                ldqTail_o,
  output logic [LDQ_LOG:0]                  ldqCnt_o,
  output logic                              ldqFull_o,
  output logic                              ldqEmpty_o
);

  logic [LDQ_LOG-1:0] head_q;
  logic [LDQ_LOG-1:0] tail_q;
  logic [LDQ_LOG:0]   cnt_q;
  logic [LDQ_LOG-1:0] slot_ptr;
  logic [NCW-1:0]     load_cnt;
  logic [LDQ_LOG+1:0] free_slots;
  logic [LDQ_LOG-1:0] head_ret;
  logic               fire;

  // Walk the bundle oldest-first; each slot sees tail plus the loads ahead of it.
  always_comb begin
    load_cnt = '0;
    slot_ptr = '0;
    ldqId_o  = '0;
    nextLd_o = '0;
    for (int i = 0; i < DISPATCH_WIDTH; i++) begin
      slot_ptr = tail_q + LDQ_LOG'(load_cnt);
      if (instLoad_i[i]) begin
        ldqId_o[i*LDQ_LOG +: LDQ_LOG] = slot_ptr;
        load_cnt = load_cnt + NCW'(1);
      end else begin
        nextLd_o[i*LDQ_LOG +: LDQ_LOG] = slot_ptr;
      end
    end
  end

  // Free space, stall and the all-or-nothing allocation decision.
  always_comb begin
`ifdef LDQ_RETIRE_BYPASS_EN
    free_slots = (LDQ_LOG+2)'(LDQ_DEPTH) - (LDQ_LOG+2)'(cnt_q) + (LDQ_LOG+2)'(retireCnt_i);
`else
    free_slots = (LDQ_LOG+2)'(LDQ_DEPTH) - (LDQ_LOG+2)'(cnt_q);
`endif
    ldqStall_o = dispatchValid_i & ((LDQ_LOG+2)'(load_cnt) > free_slots);
    fire       = dispatchValid_i & ~ldqStall_o & ~backendStall_i & ~flush_i & ~recoverValid_i;
    head_ret   = head_q + LDQ_LOG'(retireCnt_i);
  end

  // Queue pointers: reset, then flush over recovery over normal dispatch/retire.
  always_ff @(posedge clk) begin
    if (!reset) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else if (flush_i) begin
      head_q <= head_ret;
      tail_q <= head_ret;
      cnt_q  <= '0;
    end else if (recoverValid_i) begin
      head_q <= head_ret;
      tail_q <= head_q + recoverCnt_i[LDQ_LOG-1:0];
      cnt_q  <= recoverCnt_i - (LDQ_LOG+1)'(retireCnt_i);
    end else begin
      head_q <= head_ret;
      if (fire) begin
        tail_q <= tail_q + LDQ_LOG'(load_cnt);
      end
      cnt_q <= cnt_q + (fire ? (LDQ_LOG+1)'(load_cnt) : '0) - (LDQ_LOG+1)'(retireCnt_i);
    end
  end

  // Registered state views; full and empty are told apart only by the count.
  always_comb begin
    cntLdNew_o  = load_cnt;
    allocFire_o = fire;
    ldqHead_o   = head_q;
    ldqTail_o   = tail_q;
    ldqCnt_o    = cnt_q;
    ldqFull_o   = (cnt_q == (LDQ_LOG+1)'(LDQ_DEPTH));
    ldqEmpty_o  = (cnt_q == '0);
  end

  // Retiring or recovering more loads than the queue holds is a caller bug.
  a_retire_le_cnt: assert property (@(posedge clk) disable iff (!reset)
    (LDQ_LOG+1)'(retireCnt_i) <= cnt_q);
  a_recover_le_cnt: assert property (@(posedge clk) disable iff (!reset)
    recoverValid_i |-> (recoverCnt_i <= cnt_q));
  a_retire_le_recover: assert property (@(posedge clk) disable iff (!reset)
    recoverValid_i |-> ((LDQ_LOG+1)'(retireCnt_i) <= recoverCnt_i));

endmodule
